// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage 8-bit pipeline.
// Sequences load-use stalls, taken-branch flushes and data-memory waits, and
// selects EX-stage operand forwarding sources.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; new load-use or branch events are accepted
// LU_STALL | extra load-use bubbles after the first, counter counts them
// BR_FLUSH | extra flush cycles after a taken branch, counter counts them
// MEM_WAIT | pipeline frozen on mem_busy; resumes the saved state

module pipe_hazard_ctrl #(
  parameter int REG_AW            = 3,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] IF_ID_rs,
  input  logic [REG_AW-1:0] IF_ID_rt,
  input  logic [REG_AW-1:0] ID_EX_rs,
  input  logic [REG_AW-1:0] ID_EX_rt,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              ID_EX_reg_write,
  input  logic [1:0]        ID_EX_reg_write_mux,
  input  logic [REG_AW-1:0] EX_MEM_rd,
  input  logic              EX_MEM_reg_write,
  input  logic [1:0]        EX_MEM_reg_write_mux,
  input  logic [REG_AW-1:0] MEM_WB_rd,
  input  logic              MEM_WB_reg_write,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic              EX_MEM_write,
  output logic [1:0]        fwd_A,
  output logic [1:0]        fwd_B
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, BR_FLUSH, MEM_WAIT} state_t;

  localparam logic [2:0] LS_LAST = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FL_LAST = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     saved;
  state_t     eff;
  logic [2:0] cnt;
  logic       lu;
  logic       do_flush;
  logic       do_stall;

  // Hazard decode; MEM_WAIT behaves as the saved state once mem_busy drops,
  // so the resume cycle does useful work instead of idling.
  always_comb begin
    eff      = (state == MEM_WAIT) ? saved : state;
    lu       = ID_EX_reg_write && (ID_EX_reg_write_mux == 2'b10) &&
               (ID_EX_rd != '0) &&
               ((ID_EX_rd == IF_ID_rs) || (ID_EX_rd == IF_ID_rt));
    do_flush = !mem_busy && ((eff == BR_FLUSH) || branch_taken);
    do_stall = !mem_busy && !do_flush &&
               ((eff == LU_STALL) || ((eff == RUN) && lu));
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    logic ex_hit;
    logic wb_hit;
    ex_hit = EX_MEM_reg_write && (EX_MEM_rd != '0) && (EX_MEM_rd == src);
    wb_hit = MEM_WB_reg_write && (MEM_WB_rd != '0) && (MEM_WB_rd == src);
    // A load/reserved result in MEM cannot be forwarded; the load-use stall
    // ensures nobody consumes it, so fall back to the MEM_WB check.
    if (ex_hit && (EX_MEM_reg_write_mux == 2'b00))      fwd_sel = 2'b01;
    else if (ex_hit && (EX_MEM_reg_write_mux == 2'b01)) fwd_sel = 2'b10;
    else if (wb_hit)                                    fwd_sel = 2'b11;
    else                                                fwd_sel = 2'b00;
  endfunction

  // Pipeline enables, flushes and forwarding selects
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_write = 1'b1;
    fwd_A        = fwd_sel(ID_EX_rs);
    fwd_B        = fwd_sel(ID_EX_rt);
    if (reset) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_write = 1'b0;
      fwd_A        = 2'b00;
      fwd_B        = 2'b00;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      EX_MEM_write = 1'b0;
    end else if (do_flush) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (do_stall) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_flush  = 1'b1;
    end
  end

  // State, saved-state and shared counter sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      saved <= RUN;
      cnt   <= 3'd0;
    end else if (mem_busy) begin
      if (state != MEM_WAIT) begin
        saved <= state;
        state <= MEM_WAIT;
      end
    end else if (do_flush) begin
      if (eff == BR_FLUSH) begin
        if (cnt == FL_LAST) begin
          state <= RUN;
          cnt   <= 3'd0;
        end else begin
          state <= BR_FLUSH;
          cnt   <= cnt + 3'd1;
        end
      end else if (FLUSH_CYCLES > 1) begin
        state <= BR_FLUSH;
        cnt   <= 3'd1;
      end else begin
        state <= RUN;
        cnt   <= 3'd0;
      end
    end else if (do_stall) begin
      if (eff == LU_STALL) begin
        if (cnt == LS_LAST) begin
          state <= RUN;
          cnt   <= 3'd0;
        end else begin
          state <= LU_STALL;
          cnt   <= cnt + 3'd1;
        end
      end else if (LOAD_STALL_CYCLES > 1) begin
        state <= LU_STALL;
        cnt   <= 3'd1;
      end else begin
        state <= RUN;
        cnt   <= 3'd0;
      end
    end else begin
      state <= RUN;
      cnt   <= 3'd0;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating hazard statistics; idle while memory holds the pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (do_stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      if (do_flush && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2).
module tb_pipe_hazard_ctrl;

  localparam int LSC = 3;
  localparam int FLC = 2;

  logic       clk;
  logic       reset;
  logic [2:0] IF_ID_rs, IF_ID_rt, ID_EX_rs, ID_EX_rt, ID_EX_rd;
  logic       ID_EX_reg_write;
  logic [1:0] ID_EX_reg_write_mux;
  logic [2:0] EX_MEM_rd;
  logic       EX_MEM_reg_write;
  logic [1:0] EX_MEM_reg_write_mux;
  logic [2:0] MEM_WB_rd;
  logic       MEM_WB_reg_write;
  logic       branch_taken, mem_busy;
  logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write;
  logic [1:0] fwd_A, fwd_B;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count, flush_count;
  int          m_stall_cnt, m_flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];
  int         stall_left, flush_left;

  pipe_hazard_ctrl #(.REG_AW(3), .LOAD_STALL_CYCLES(LSC), .FLUSH_CYCLES(FLC)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_reg_write_mux(ID_EX_reg_write_mux),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write(EX_MEM_reg_write),
    .EX_MEM_reg_write_mux(EX_MEM_reg_write_mux),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_reg_write(MEM_WB_reg_write),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .EX_MEM_write(EX_MEM_write),
    .fwd_A(fwd_A), .fwd_B(fwd_B)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_lu();
    return ID_EX_reg_write && (ID_EX_reg_write_mux == 2'b10) && (ID_EX_rd != 3'd0) &&
           ((ID_EX_rd == IF_ID_rs) || (ID_EX_rd == IF_ID_rt));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [2:0] s);
    if (s != 3'd0 && EX_MEM_reg_write && EX_MEM_rd == s) begin
      case (EX_MEM_reg_write_mux)
        2'b00: return 2'b01;
        2'b01: return 2'b10;
        default: ;
      endcase
    end
    if (s != 3'd0 && MEM_WB_reg_write && MEM_WB_rd == s) return 2'b11;
    return 2'b00;
  endfunction

  // Expected vector: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, fwd_A, fwd_B}
  function automatic logic [8:0] model_out();
    logic [3:0] fw;
    fw = {m_fwd(ID_EX_rs), m_fwd(ID_EX_rt)};
    if (reset)                                 return {5'b00110, 4'b0000};
    if (mem_busy)                              return {5'b00000, fw};
    if (flush_left > 0 || branch_taken)        return {5'b11111, fw};
    if (stall_left > 0 || m_lu())              return {5'b00011, fw};
    return {5'b11001, fw};
  endfunction

  task automatic model_step();
    if (reset) begin
      stall_left = 0; flush_left = 0;
`ifdef HAZARD_STATS_EN
      m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    end else if (!mem_busy) begin
      if (flush_left > 0 || branch_taken) begin
`ifdef HAZARD_STATS_EN
        if (m_flush_cnt < 65535) m_flush_cnt++;
`endif
        if (flush_left > 0) flush_left--;
        else begin flush_left = FLC - 1; stall_left = 0; end
      end else if (stall_left > 0 || m_lu()) begin
`ifdef HAZARD_STATS_EN
        if (m_stall_cnt < 65535) m_stall_cnt++;
`endif
        if (stall_left > 0) stall_left--;
        else stall_left = LSC - 1;
      end
    end
  endtask

  // One clock: inputs already driven at the falling edge; push expectation,
  // sample mid-low-phase, pop and compare, then advance the model.
  task automatic cyc(input string tag);
    logic [8:0] e;
    #1;
    exp_q.push_back(model_out());
    #1;
    e = exp_q.pop_front();
    chk(tag, {23'd0, pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, fwd_A, fwd_B},
        {23'd0, e});
    model_step();
    @(negedge clk);
  endtask

  task automatic clr();
    IF_ID_rs = 0; IF_ID_rt = 0; ID_EX_rs = 0; ID_EX_rt = 0; ID_EX_rd = 0;
    ID_EX_reg_write = 0; ID_EX_reg_write_mux = 0;
    EX_MEM_rd = 0; EX_MEM_reg_write = 0; EX_MEM_reg_write_mux = 0;
    MEM_WB_rd = 0; MEM_WB_reg_write = 0; branch_taken = 0; mem_busy = 0;
  endtask

  task automatic set_lu();
    ID_EX_reg_write = 1; ID_EX_reg_write_mux = 2'b10; ID_EX_rd = 3'd3; IF_ID_rs = 3'd3;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    stall_left = 0; flush_left = 0;
`ifdef HAZARD_STATS_EN
    m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    @(negedge clk);
    cyc("reset0");
    cyc("reset1");
    reset = 1'b0;
    cyc("idle");

    // load-use: stall for LSC cycles, inputs dropped after the first
    set_lu();
    cyc("lu0");
    clr();
    for (int i = 1; i < LSC; i++) cyc("lu_stall");
    cyc("lu_done");
    // register 0 never creates a hazard
    set_lu(); ID_EX_rd = 0; IF_ID_rs = 0;
    cyc("lu_r0");
    clr();

    // forwarding priorities
    EX_MEM_rd = 2; EX_MEM_reg_write = 1; EX_MEM_reg_write_mux = 2'b01;
    MEM_WB_rd = 2; MEM_WB_reg_write = 1; ID_EX_rs = 2; ID_EX_rt = 2;
    cyc("fwd_shift");
    EX_MEM_reg_write_mux = 2'b00;  cyc("fwd_alu");
    EX_MEM_reg_write_mux = 2'b10;  cyc("fwd_load_fall");
    EX_MEM_reg_write = 0;          cyc("fwd_wb");
    ID_EX_rt = 5;                  cyc("fwd_b_none");
    ID_EX_rs = 0; MEM_WB_rd = 0; EX_MEM_rd = 0; EX_MEM_reg_write = 1;
    cyc("fwd_r0");
    clr();

    // branch pulse: flush for FLC cycles
    branch_taken = 1; cyc("br0");
    branch_taken = 0;
    for (int i = 1; i < FLC; i++) cyc("br_flush");
    cyc("br_done");

    // branch together with load-use: branch wins
    set_lu(); branch_taken = 1; cyc("br_lu");
    clr(); for (int i = 1; i < FLC; i++) cyc("br_lu_flush");
    cyc("br_lu_done");

    // branch arriving mid-stall aborts it
    set_lu(); cyc("lu_a");
    clr(); branch_taken = 1; cyc("lu_abort_br");
    branch_taken = 0; for (int i = 1; i < FLC; i++) cyc("lu_abort_flush");
    cyc("lu_abort_done");

    // memory wait during BR_FLUSH at counter=1
    branch_taken = 1; cyc("mw_br");
    branch_taken = 0; mem_busy = 1;
    for (int i = 0; i < 3; i++) cyc("mw_busy");
    mem_busy = 0; cyc("mw_resume_flush");
    cyc("mw_run");

    // reset in the middle of a stall
    set_lu(); cyc("rs_lu");
    clr(); cyc("rs_stall");
    reset = 1'b1; cyc("rs_reset");
    reset = 1'b0; cyc("rs_after");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      IF_ID_rs = 3'($urandom_range(0, 7)); IF_ID_rt = 3'($urandom_range(0, 7));
      ID_EX_rs = 3'($urandom_range(0, 7)); ID_EX_rt = 3'($urandom_range(0, 7));
      ID_EX_rd = 3'($urandom_range(0, 7));
      ID_EX_reg_write = 1'($urandom_range(0, 1));
      ID_EX_reg_write_mux = 2'($urandom_range(0, 3));
      EX_MEM_rd = 3'($urandom_range(0, 7)); EX_MEM_reg_write = 1'($urandom_range(0, 1));
      EX_MEM_reg_write_mux = 2'($urandom_range(0, 3));
      MEM_WB_rd = 3'($urandom_range(0, 7)); MEM_WB_reg_write = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy = ($urandom_range(0, 7) == 0);
      cyc("rand");
    end
    clr();
    cyc("rand_end");

`ifdef HAZARD_STATS_EN
    chk("stall_count_mix", {16'd0, stall_count}, m_stall_cnt);
    chk("flush_count_mix", {16'd0, flush_count}, m_flush_cnt);
    reset = 1'b1; cyc("st_reset"); reset = 1'b0;
    set_lu(); cyc("st_lu1"); clr();
    for (int i = 1; i < LSC; i++) cyc("st_lu1s");
    set_lu(); cyc("st_lu2"); clr();
    for (int i = 1; i < LSC; i++) cyc("st_lu2s");
    branch_taken = 1; cyc("st_br"); branch_taken = 0;
    for (int i = 1; i < FLC; i++) cyc("st_brf");
    chk("stall_count_2lu", {16'd0, stall_count}, 2 * LSC);
    chk("flush_count_1br", {16'd0, flush_count}, FLC);
    set_lu();
    for (int i = 0; i < 70000; i++) cyc("st_sat");
    clr();
    chk("stall_count_sat", {16'd0, stall_count}, 32'h0000FFFF);
    chk("stall_count_sat_m", {16'd0, stall_count}, m_stall_cnt);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
